// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the MEM-stage load/store unit:
//   - MIPS load/store opcode constants
//   - load/store unit FSM state encoding
//   - helper functions for index width and opcode classification
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam int MEM_WORDS_DEFAULT = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_MERGE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  // Word-index width for a memory of the given depth (at least 1 bit).
  function automatic int idx_width(input int words);
    if (words > 1) begin
      return $clog2(words);
    end else begin
      return 1;
    end
  endfunction

  // Opcode is one of the eight supported loads/stores.
  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  // Sub-word stores that need a read-modify-write sequence.
  function automatic logic is_rmw_op(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  // Word ops need addr[1:0]==0, halfword ops need addr[0]==0; bytes never misalign.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
//   Combinational load formatter: selects the addressed half/byte lane of a
//   memory word (little-endian, byte 0 = bits [7:0]) and sign- or
//   zero-extends it according to the load opcode.
// Ports
//   word_i     [31:0] word read from data memory
//   byte_off_i [1:0]  byte offset within the word (addr[1:0])
//   opcode_i   [5:0]  load opcode
//   data_o     [31:0] extended load value (0 for non-load opcodes)
// ----------------------------------------------------------------------------
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [5:0]  opcode_i,
  output logic [31:0] data_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Lane selection: half chosen by addr[1], byte by addr[1:0].
  always_comb begin
    half_sel = 16'h0000;
    byte_sel = 8'h00;
    if (byte_off_i[1]) begin
      half_sel = word_i[31:16];
    end else begin
      half_sel = word_i[15:0];
    end
    case (byte_off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
  end

  // Extension per opcode.
  always_comb begin
    data_o = 32'h0000_0000;
    case (opcode_i)
      OP_LW:   data_o = word_i;
      OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data_o = {16'h0000, half_sel};
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'h00_0000, byte_sel};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   MEM-stage controller between the EX result and a word-wide data memory.
//   Executes lw/lh/lhu/lb/lbu/sw/sh/sb. Loads are extended by load_extend;
//   sh/sb are read-modify-write. All outputs are registered.
//
//   Sequencing (edges counted from the accept edge):
//     error : IDLE -> RESP
//     sw    : IDLE -> WR -> RESP
//     load  : IDLE -> RD(strobe) -> RD(data wait) -> RESP
//     sh/sb : IDLE -> RD(strobe) -> RD(data wait) -> MERGE -> RESP
//   The memory has a registered read: mem_rdata is valid after the edge that
//   ends the strobe cycle, so RD lasts two cycles and samples on the second.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_opcode/addr/wdata/rt   request fields, captured on accept
//   mem_idx                    word index addr[IDX_W+1:2], stable for the op
//   mem_read/mem_write         one-cycle strobes, never both high
//   mem_wdata                  full word to write
//   mem_rdata                  word from memory (registered read)
//   resp_valid                 one-cycle completion pulse
//   resp_load/rt/data/err      completion info, qualified by resp_valid
// ----------------------------------------------------------------------------
module load_store_unit
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [5:0]                          req_opcode,
  input  logic [31:0]                         req_addr,
  input  logic [31:0]                         req_wdata,
  input  logic [4:0]                          req_rt,
  output logic [mips_pkg::idx_width(MEM_WORDS)-1:0] mem_idx,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [31:0]                         mem_wdata,
  input  logic [31:0]                         mem_rdata,
  output logic                                resp_valid,
  output logic                                resp_load,
  output logic [4:0]                          resp_rt,
  output logic [31:0]                         resp_data,
  output logic                                resp_err
);

  localparam int IDX_W = idx_width(MEM_WORDS);

  lsu_state_t        state_q;
  logic              rd_wait_q;
  logic [5:0]        op_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rt_q;

  logic              req_ready_q;
  logic [IDX_W-1:0]  mem_idx_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [31:0]       mem_wdata_q;
  logic              resp_valid_q;
  logic              resp_load_q;
  logic [4:0]        resp_rt_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;

  logic              acc_err;
  logic [31:0]       ext_data;
  logic [31:0]       merge_word_d;
  logic              unused_addr_hi;

  // Address bits above the word index are intentionally ignored (index wraps).
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];

  // Accept-time decode: illegal opcode or misalignment short-circuits to RESP.
  always_comb begin
    acc_err = 1'b0;
    if (!is_legal_op(req_opcode)) begin
      acc_err = 1'b1;
    end else begin
      acc_err = is_misaligned(req_opcode, req_addr[1:0]);
    end
  end

  load_extend u_load_extend (
    .word_i     (mem_rdata),
    .byte_off_i (addr_lo_q),
    .opcode_i   (op_q),
    .data_o     (ext_data)
  );

  // Read-modify-write merge: replace only the addressed lane of the read word.
  always_comb begin
    merge_word_d = mem_rdata;
    if (op_q == OP_SH) begin
      if (addr_lo_q[1]) begin
        merge_word_d[31:16] = wdata_q[15:0];
      end else begin
        merge_word_d[15:0] = wdata_q[15:0];
      end
    end else begin
      case (addr_lo_q)
        2'd0:    merge_word_d[7:0]   = wdata_q[7:0];
        2'd1:    merge_word_d[15:8]  = wdata_q[7:0];
        2'd2:    merge_word_d[23:16] = wdata_q[7:0];
        2'd3:    merge_word_d[31:24] = wdata_q[7:0];
        default: merge_word_d        = mem_rdata;
      endcase
    end
  end

  // Control FSM with registered outputs; strobes and response default low each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_wait_q    <= 1'b0;
      op_q         <= 6'd0;
      addr_lo_q    <= 2'd0;
      wdata_q      <= 32'h0000_0000;
      rt_q         <= 5'd0;
      req_ready_q  <= 1'b1;
      mem_idx_q    <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_load_q  <= 1'b0;
      resp_rt_q    <= 5'd0;
      resp_data_q  <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_load_q  <= 1'b0;
      resp_rt_q    <= 5'd0;
      resp_data_q  <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q        <= req_opcode;
            addr_lo_q   <= req_addr[1:0];
            wdata_q     <= req_wdata;
            rt_q        <= req_rt;
            mem_idx_q   <= req_addr[IDX_W+1:2];
            req_ready_q <= 1'b0;
            rd_wait_q   <= 1'b0;
            if (acc_err) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rt_q    <= req_rt;
            end else if (req_opcode == OP_SW) begin
              state_q     <= ST_WR;
              mem_write_q <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q    <= ST_RD;
              mem_read_q <= 1'b1;
            end
          end else begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        ST_RD: begin
          if (!rd_wait_q) begin
            // Strobe cycle done; memory presents the word after this edge.
            rd_wait_q <= 1'b1;
          end else if (is_rmw_op(op_q)) begin
            state_q     <= ST_MERGE;
            mem_write_q <= 1'b1;
            mem_wdata_q <= merge_word_d;
          end else begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_load_q  <= 1'b1;
            resp_rt_q    <= rt_q;
            resp_data_q  <= ext_data;
          end
        end
        ST_WR, ST_MERGE: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_rt_q    <= rt_q;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_idx    = mem_idx_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_load  = resp_load_q;
  assign resp_rt    = resp_rt_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//   Scoreboard bench: a reference model computes each op's expected response
//   when it is driven and pushes it to a queue; a negedge monitor pops and
//   compares whenever the DUT pulses resp_valid. A 256x32 registered-read
//   memory model sits on the memory port.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rt;
  logic [7:0]  mem_idx;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_load;
  logic [4:0]  resp_rt;
  logic [31:0] resp_data;
  logic        resp_err;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rt     (req_rt),
    .mem_idx    (mem_idx),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_load  (resp_load),
    .resp_rt    (resp_rt),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        load;
    logic [4:0]  rt;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [7:0]  last_rd_idx = 8'd0;
  logic [7:0]  last_wr_idx = 8'd0;

  // Memory model with a backdoor write port for preload.
  logic [31:0] mem_arr [0:255];
  logic [31:0] ref_mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem_arr[bd_idx] <= bd_data;
    else if (mem_write) mem_arr[mem_idx] <= mem_wdata;
    if (mem_read) mem_rdata <= mem_arr[mem_idx];
  end

  // Cycle counter, accept times and strobe statistics.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && req_valid && req_ready) acc_q.push_back(cyc + 1);
    if (mem_read) begin
      rd_cnt <= rd_cnt + 1;
      last_rd_idx <= mem_idx;
    end
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      last_wr_idx <= mem_idx;
    end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Response monitor: compare every completion against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        check_val("resp_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
        check_val({e.name, "_err"},  {31'd0, resp_err},  {31'd0, e.err});
        check_val({e.name, "_load"}, {31'd0, resp_load}, {31'd0, e.load});
        check_val({e.name, "_data"}, resp_data, e.data);
        check_val({e.name, "_ready_low"}, {31'd0, req_ready}, 32'd0);
        if (e.load) check_val({e.name, "_rt"}, {27'd0, resp_rt}, {27'd0, e.rt});
        if (e.lat != 0) check_val({e.name, "_lat"}, 32'(cyc - a + 1), 32'(e.lat));
      end
    end
  end

  // Reference model: compute the expected response and update the shadow memory.
  task automatic model_push(input string name, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [4:0] rt);
    exp_t        e;
    logic [7:0]  idx;
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    bit          legal;
    bit          mis;
    idx   = addr[9:2];
    w     = ref_mem[idx];
    h     = addr[1] ? w[31:16] : w[15:0];
    b     = w[8*addr[1:0] +: 8];
    legal = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    mis   = ((op == 6'h23 || op == 6'h2B) && addr[1:0] != 2'b00) ||
            ((op == 6'h21 || op == 6'h25 || op == 6'h29) && addr[0]);
    e.name = name; e.load = 1'b0; e.rt = rt; e.data = 32'd0; e.err = 1'b0; e.lat = 0;
    if (!legal || mis) begin
      e.err = 1'b1; e.lat = 1;
    end else begin
      case (op)
        6'h23: begin e.load = 1'b1; e.data = w; e.lat = 3; end
        6'h21: begin e.load = 1'b1; e.data = {{16{h[15]}}, h}; e.lat = 3; end
        6'h25: begin e.load = 1'b1; e.data = {16'd0, h}; e.lat = 3; end
        6'h20: begin e.load = 1'b1; e.data = {{24{b[7]}}, b}; e.lat = 3; end
        6'h24: begin e.load = 1'b1; e.data = {24'd0, b}; e.lat = 3; end
        6'h2B: begin ref_mem[idx] = wd; e.lat = 2; end
        6'h29: ref_mem[idx][16*addr[1] +: 16] = wd[15:0];
        6'h28: ref_mem[idx][8*addr[1:0] +: 8] = wd[7:0];
        default: e.err = 1'b1;
      endcase
    end
    exp_q.push_back(e);
  endtask

  // Drive one request and wait (bounded) for it to be accepted.
  task automatic drive_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rt, input bit keep);
    bit accepted = 1'b0;
    @(negedge clk);
    req_opcode = op; req_addr = addr; req_wdata = wd; req_rt = rt; req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        @(posedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("accept", {31'd0, accepted}, 32'd1);
    #1;
    // Scramble the request bus: the DUT must work from its captured copy.
    req_opcode = 6'h2B; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_rt = 5'd31;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rt, input bit keep);
    model_push(name, op, addr, wd, rt);
    drive_req(op, addr, wd, rt, keep);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check_val({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic backdoor(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    ref_mem[idx] = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int rd0;
    int wr0;
    logic [31:0] w5;
    reset = 1'b1; req_valid = 1'b0; req_opcode = 6'd0; req_addr = 32'd0;
    req_wdata = 32'd0; req_rt = 5'd0; bd_we = 1'b0; bd_idx = 8'd0; bd_data = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check_val("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check_val("rst_mem_idx", {24'd0, mem_idx}, 32'd0);
    check_val("rst_resp_data", resp_data, 32'd0);
    reset = 1'b0;

    backdoor(8'd0, 32'h0000_0000);
    backdoor(8'd5, 32'h8899_AABB);
    backdoor(8'd8, 32'h1122_3344);

    // T1: lb, one read strobe at index 5
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op("t1_lb", 6'h20, 32'h0000_0015, 32'd0, 5'd3, 1'b0);
    drain("t1");
    check_val("t1_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
    check_val("t1_wr_cnt", 32'(wr_cnt - wr0), 32'd0);
    check_val("t1_rd_idx", {24'd0, last_rd_idx}, 32'd5);
    check_val("t1_model", exp_q.size() == 0 ? 32'hFFFF_FFAA : 32'd0, 32'hFFFF_FFAA);

    // T1b: lbu of the top byte
    run_op("t1b_lbu", 6'h24, 32'h0000_0017, 32'd0, 5'd4, 1'b0);
    drain("t1b");

    // T2: sb read-modify-write
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op("t2_sb", 6'h28, 32'h0000_0016, 32'h1234_56CC, 5'd0, 1'b0);
    drain("t2");
    check_val("t2_word5", mem_arr[5], 32'h88CC_AABB);
    check_val("t2_rd_cnt", 32'(rd_cnt - rd0), 32'd1);
    check_val("t2_wr_cnt", 32'(wr_cnt - wr0), 32'd1);

    // T3: sh upper lane, then lh / lhu / lw readback
    run_op("t3_sh", 6'h29, 32'h0000_0016, 32'h0000_BEEF, 5'd0, 1'b0);
    drain("t3");
    check_val("t3_word5", mem_arr[5], 32'hBEEF_AABB);
    run_op("t3b_lh", 6'h21, 32'h0000_0016, 32'd0, 5'd7, 1'b0);
    run_op("t3c_lhu", 6'h25, 32'h0000_0014, 32'd0, 5'd8, 1'b0);
    run_op("t3d_lw", 6'h23, 32'h0000_0014, 32'd0, 5'd9, 1'b0);
    drain("t3bcd");

    // T4: misaligned sw / lh and illegal opcode never touch memory
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op("t4_sw_mis", 6'h2B, 32'h0000_0401, 32'hDEAD_BEEF, 5'd1, 1'b0);
    run_op("t4_lh_mis", 6'h21, 32'h0000_0015, 32'd0, 5'd2, 1'b0);
    run_op("t4_illegal", 6'h3F, 32'h0000_0014, 32'd0, 5'd3, 1'b0);
    drain("t4");
    check_val("t4_rd_cnt", 32'(rd_cnt - rd0), 32'd0);
    check_val("t4_wr_cnt", 32'(wr_cnt - wr0), 32'd0);

    // T4b: sw index wraps to word 0
    run_op("t4b_sw_wrap", 6'h2B, 32'h0000_0400, 32'hCAFE_F00D, 5'd0, 1'b0);
    drain("t4b");
    check_val("t4b_word0", mem_arr[0], 32'hCAFE_F00D);
    check_val("t4b_wr_idx", {24'd0, last_wr_idx}, 32'd0);

    // T5: reset during the MERGE write cycle of sb
    w5 = ref_mem[5];
    drive_req(6'h28, 32'h0000_0014, 32'h0000_0077, 5'd0, 1'b0);
    for (int i = 0; i < 10 && !mem_write; i++) @(negedge clk);
    check_val("t5_merge_seen", {31'd0, mem_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("t5_rst_write", {31'd0, mem_write}, 32'd0);
    check_val("t5_rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("t5_rst_idx", {24'd0, mem_idx}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    acc_q.delete();
    @(negedge clk);
    check_val("t5_word5", mem_arr[5], w5);

    // T5b: back-to-back with req_valid held high
    run_op("t5b_lw", 6'h23, 32'h0000_0014, 32'd0, 5'd10, 1'b1);
    run_op("t5b_sw", 6'h2B, 32'h0000_0020, 32'h8081_8283, 5'd0, 1'b1);
    run_op("t5b_lbu", 6'h24, 32'h0000_0020, 32'd0, 5'd11, 1'b1);
    run_op("t5b_lb", 6'h20, 32'h0000_0023, 32'd0, 5'd12, 1'b1);
    run_op("t5b_err", 6'h21, 32'h0000_0021, 32'd0, 5'd13, 1'b0);
    drain("t5b");
    check_val("t5b_word8", mem_arr[8], 32'h8081_8283);

    check_val("both_strobes", 32'(both_cnt), 32'd0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
